axi_write_slave: RTL and testbench
==================================

# axi_write_slave

AXI4 write-channel slave that terminates the AW/W/B channels driven by the write-channel master (`axi_protocol` / `Write_Channel`) and stores accepted data in a byte-strobed local memory. It accepts one burst at a time, counts beats against `axi_awlen`, checks `axi_wlast` placement, and returns OKAY or SLVERR on B. It is the downstream stage instantiated beside the master in the verification wrapper, and gives the master a real responder instead of free inputs. A debug read port exposes memory contents to the bench.

## Interface
- `AW`, 32, address width
- `DW`, 64, data width; fixed at 64 (8 byte lanes)
- `DEPTH`, 256, memory depth in 64-bit words; power of two

- `clk` in 1: single clock, rising edge
- `resetn` in 1: asynchronous, active-low reset
- `axi_awaddr` in AW: burst start byte address
- `axi_awlen` in 8: beats minus one
- `axi_awsize` in 3: log2 bytes per beat
- `axi_awburst` in 2: burst type
- `axi_awvalid` in 1 / `axi_awready` out 1: AW handshake
- `axi_wdata` in 64 / `axi_wstrb` in 8 / `axi_wlast` in 1: write beat
- `axi_wvalid` in 1 / `axi_wready` out 1: W handshake
- `axi_bresp` out 2 / `axi_bvalid` out 1 / `axi_bready` in 1: B handshake
- `dbg_addr` in log2(DEPTH): debug word index
- `dbg_rdata` out 64: memory word at `dbg_addr`, registered

## Operation
- States:
  - IDLE: `awready`=1.
  - DATA: `wready`=1.
  - RESP: `bvalid`=1.
- IDLE -> DATA on `awvalid & awready`.
  - Latch addr, len, size, burst.
  - Clear beat counter and error flag.
- DATA: each `wvalid & wready` is one beat.
  - For each byte lane i with `wstrb[i]`=1, write `wdata[8i+7:8i]` into word `addr[3 +: log2 DEPTH]`. Lanes with strobe 0 are left unchanged.
  - After the beat, the beat counter increments.
  - INCR: addr += 1<<size. FIXED: addr unchanged.
- DATA -> RESP on the beat where counter == latched len. Burst length is set by `awlen` only.
- RESP -> IDLE on `bvalid & bready`.
- Error flag (sticky per burst). Any of these makes `bresp`=SLVERR (2'b10); otherwise OKAY (2'b00):
  - `awburst` is WRAP or reserved.
  - `awsize` > 3.
  - `wlast`=1 on a non-final beat.
  - `wlast`=0 on the final beat.
  - A beat address ≥ DEPTH*8.
- Beats with an out-of-range address, or in a burst with unsupported burst type or size, are accepted but not written.
- Address arithmetic is AW bits wide and wraps modulo 2^AW. No 4 KB boundary check.
- W beats presented before the AW handshake are not accepted (`wready`=0).
- Memory is not reset; its contents survive `resetn`.

## Timing
- Reset values:
  - `awready`=0, `wready`=0, `bvalid`=0, `bresp`=2'b00, `dbg_rdata`=0.
  - State = IDLE.
- All outputs are registered. `awready` rises on the first `clk` edge after `resetn` deasserts.
- AW handshake at edge N:
  - `awready` falls and `wready` rises, both visible after edge N.
  - First beat can be accepted at edge N+1.
- One beat per cycle while `wvalid` is held. A write is visible on `dbg_rdata` two edges after its beat: one edge for the memory write, one for the registered debug read.
- Final beat at edge M: `wready` falls and `bvalid` rises with final `bresp`, both visible after M.
- `bvalid`/`bresp` are held stable until `bready`.
- B handshake at edge K: `awready`=1 after K.
- Minimum burst cost: awlen+3 cycles (AW, beats, B).
- AW and W valid in the same cycle in IDLE: only AW is accepted.
- `resetn` low at any point, including mid-burst or during RESP:
  - Immediate return to IDLE, all handshake outputs 0.
  - The partial burst is abandoned and gets no B response.
  - Memory writes already made persist.

## Structure
- Shared package `axi_pkg` holds:
  - Burst encodings: `BURST_FIXED`=2'b00, `BURST_INCR`=2'b01, `BURST_WRAP`=2'b10.
  - Response codes: `RESP_OKAY`=2'b00, `RESP_SLVERR`=2'b10.
  - The slave state enum (IDLE/DATA/RESP).
- One sub-module, `axi_slave_mem`, holds the memory: DEPTH×64 storage, 8 byte-enable write lanes, one write port, one registered read port for debug.
- FSM, beat counter, address stepping and error logic live in `axi_write_slave`.

## Test plan
- Single beat: AW addr=0x10, len=0, size=3, INCR; W data=0x1122334455667788, strb=0xFF, wlast=1.
  - `bvalid` 1 cycle after the beat, `bresp`=OKAY.
  - `dbg_addr`=2 reads 0x1122334455667788.
- INCR burst: addr=0x0, len=3, size=3, data 0xA0..0xA3, wlast on beat 3.
  - Words 0..3 hold 0xA0..0xA3.
  - OKAY; 6 cycles from AW to B.
- Strobes and FIXED: addr=0x8, len=1, FIXED.
  - Beat 0 strb=0x0F, data=0xFFFFFFFF_FFFFFFFF; beat 1 strb=0xF0, data=0x0.
  - Word 1 = 0x00000000_FFFFFFFF; OKAY.
- Protocol errors:
  - len=1 with wlast on beat 0 -> both beats written, SLVERR.
  - WRAP burst -> no writes, SLVERR.
  - addr=0x800 with DEPTH=256 -> no write, SLVERR.
- Backpressure: `bready` held 0 for 5 cycles.
  - `bvalid`/`bresp` stable, `awready`=0 throughout.
  - `awready`=1 the cycle after `bready` rises.
- Reset mid-burst: `resetn` low after beat 1 of a len=3 burst.
  - All handshake outputs 0 immediately, no B response.
  - Words written before reset retained; a new burst after release completes OKAY.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared AXI write-slave definitions: burst/response encodings, slave FSM states
// and the check for burst types and sizes the slave can store.
package axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int unsigned MAX_SIZE = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_RESP = 2'd2
  } slv_state_t;

  // Only FIXED/INCR bursts with at most 8 bytes per beat are stored
  function automatic logic burst_supported(input logic [1:0] burst, input logic [2:0] size);
    logic ok;
    case (burst)
      BURST_FIXED, BURST_INCR: ok = 1'b1;
      BURST_WRAP:              ok = 1'b0;
      default:                 ok = 1'b0;
    endcase
    return ok && (size <= 3'(MAX_SIZE));
  endfunction

endpackage

// File: rtl/axi_write_slave_if.sv
// AXI4 write-channel bundle (AW/W/B) between the write master and the slave.
interface axi_write_slave_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 64
);
  logic [AW-1:0]   axi_awaddr;
  logic [7:0]      axi_awlen;
  logic [2:0]      axi_awsize;
  logic [1:0]      axi_awburst;
  logic            axi_awvalid;
  logic            axi_awready;
  logic [DW-1:0]   axi_wdata;
  logic [DW/8-1:0] axi_wstrb;
  logic            axi_wlast;
  logic            axi_wvalid;
  logic            axi_wready;
  logic [1:0]      axi_bresp;
  logic            axi_bvalid;
  logic            axi_bready;

  modport master (
    output axi_awaddr, axi_awlen, axi_awsize, axi_awburst, axi_awvalid,
    output axi_wdata, axi_wstrb, axi_wlast, axi_wvalid,
    output axi_bready,
    input  axi_awready, axi_wready, axi_bresp, axi_bvalid
  );

  modport slave (
    input  axi_awaddr, axi_awlen, axi_awsize, axi_awburst, axi_awvalid,
    input  axi_wdata, axi_wstrb, axi_wlast, axi_wvalid,
    input  axi_bready,
    output axi_awready, axi_wready, axi_bresp, axi_bvalid
  );
endinterface

// File: rtl/axi_slave_mem.sv
// Byte-lane write memory behind the write slave, with a registered debug read port.
// Storage is deliberately not reset so contents survive resetn.
module axi_slave_mem #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned DW    = 64
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [DW/8-1:0]          i_wstrb,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [DW-1:0]            i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [DW-1:0]            o_rdata
);
  localparam int unsigned NBL = DW / 8;

  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_rdata;

  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(NBL); i++) begin
      if (i_wstrb[i]) r_mem[i_waddr][8*i +: 8] <= i_wdata[8*i +: 8];
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_rdata <= '0;
    else         r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/axi_write_slave.sv
// AXI4 write slave: accepts one burst at a time, stores strobed bytes into local
// memory, and answers OKAY/SLVERR on B after checking wlast placement and range.
module axi_write_slave
  import axi_pkg::*;
#(
  parameter int unsigned AW    = 32,
  parameter int unsigned DW    = 64,
  parameter int unsigned DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     resetn,
  axi_write_slave_if.slave         axi,
  input  logic [$clog2(DEPTH)-1:0] dbg_addr,
  output logic [DW-1:0]            dbg_rdata
);
  localparam int unsigned AIW = $clog2(DEPTH);
  localparam int unsigned NBL = DW / 8;

  slv_state_t      r_state;
  logic [AW-1:0]   r_addr;
  logic [7:0]      r_len;
  logic [7:0]      r_cnt;
  logic [2:0]      r_size;
  logic [1:0]      r_burst;
  logic            r_err;
  logic            r_skip;
  logic            r_awready;
  logic            r_wready;
  logic            r_bvalid;
  logic [1:0]      r_bresp;

  logic            w_beat;
  logic            w_final;
  logic            w_in_range;
  logic            w_beat_err;
  logic [AW-1:0]   w_step;
  logic [NBL-1:0]  w_strb;

  assign w_beat     = axi.axi_wvalid & r_wready;
  assign w_final    = (r_cnt == r_len);
  // In range means below DEPTH*8 bytes, i.e. no address bits above the word index
  assign w_in_range = (r_addr[AW-1:AIW+3] == '0);
  assign w_beat_err = (axi.axi_wlast != w_final) | ~w_in_range;
  assign w_step     = (r_burst == BURST_INCR) ? (AW'(1) << r_size) : '0;
  assign w_strb     = (w_beat && !r_skip && w_in_range) ? axi.axi_wstrb : '0;

  assign axi.axi_awready = r_awready;
  assign axi.axi_wready  = r_wready;
  assign axi.axi_bvalid  = r_bvalid;
  assign axi.axi_bresp   = r_bresp;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= ST_IDLE;
      r_addr    <= '0;
      r_len     <= '0;
      r_cnt     <= '0;
      r_size    <= '0;
      r_burst   <= '0;
      r_err     <= 1'b0;
      r_skip    <= 1'b0;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bresp   <= RESP_OKAY;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (r_awready && axi.axi_awvalid) begin
            r_addr    <= axi.axi_awaddr;
            r_len     <= axi.axi_awlen;
            r_size    <= axi.axi_awsize;
            r_burst   <= axi.axi_awburst;
            r_cnt     <= '0;
            r_skip    <= ~burst_supported(axi.axi_awburst, axi.axi_awsize);
            r_err     <= ~burst_supported(axi.axi_awburst, axi.axi_awsize);
            r_awready <= 1'b0;
            r_wready  <= 1'b1;
            r_state   <= ST_DATA;
          end else begin
            r_awready <= 1'b1;
          end
        end
        ST_DATA: begin
          if (w_beat) begin
            r_addr <= r_addr + w_step;
            if (w_final) begin
              r_wready <= 1'b0;
              r_bvalid <= 1'b1;
              r_bresp  <= (r_err || w_beat_err) ? RESP_SLVERR : RESP_OKAY;
              r_state  <= ST_RESP;
            end else begin
              r_cnt <= r_cnt + 8'd1;
              r_err <= r_err | w_beat_err;
            end
          end
        end
        ST_RESP: begin
          if (axi.axi_bready) begin
            r_bvalid  <= 1'b0;
            r_awready <= 1'b1;
            r_state   <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  axi_slave_mem #(
    .DEPTH (DEPTH),
    .DW    (DW)
  ) u_mem (
    .clk     (clk),
    .resetn  (resetn),
    .i_wstrb (w_strb),
    .i_waddr (r_addr[3 +: AIW]),
    .i_wdata (axi.axi_wdata),
    .i_raddr (dbg_addr),
    .o_rdata (dbg_rdata)
  );

endmodule

// File: tb/tb_axi_write_slave.sv
// Scoreboard bench for axi_write_slave: a byte-array reference model predicts
// B responses and memory words; a monitor process compares them against the DUT.
module tb_axi_write_slave;
  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 64;
  localparam int unsigned DEPTH = 256;
  localparam int unsigned AIW   = 8;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  axi_write_slave_if #(.AW(AW), .DW(DW)) axi ();
  logic [AIW-1:0] dbg_addr;
  logic [63:0]    dbg_rdata;

  axi_write_slave #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .axi       (axi),
    .dbg_addr  (dbg_addr),
    .dbg_rdata (dbg_rdata)
  );

  typedef struct { logic [1:0] resp; int lat; } bexp_t;
  typedef struct { int due; int idx; logic [63:0] exp; } dexp_t;

  bexp_t      bq[$];
  dexp_t      dq[$];
  logic [7:0] mref [DEPTH*8];
  logic [63:0] bdata [256];
  logic [7:0]  bstrb [256];

  int n_vec = 0;
  int n_err = 0;
  int ncyc  = 0;
  bit fin_req  = 1'b0;
  bit fin_done = 1'b0;

  // Monitor: every comparison happens here, sampled on the falling edge
  initial begin
    int  aw_cyc = 0;
    bit  exp_aw = 1'b0;
    bit  bv_prev = 1'b0;
    int  rel = 0;
    forever begin
      @(negedge clk);
      ncyc++;
      if (!resetn) begin
        n_vec++;
        if (axi.axi_awready || axi.axi_wready || axi.axi_bvalid || axi.axi_bresp != 2'b00 || dbg_rdata != 64'd0) begin
          n_err++;
          $display("FAIL reset_outputs: aw=%0b w=%0b b=%0b resp=%0d dbg=%h, required all zero",
                   axi.axi_awready, axi.axi_wready, axi.axi_bvalid, axi.axi_bresp, dbg_rdata);
        end
        exp_aw = 1'b0; bv_prev = 1'b0; rel = 0;
      end else begin
        rel++;
        if (rel == 2) begin
          n_vec++;
          if (axi.axi_awready !== 1'b1) begin
            n_err++;
            $display("FAIL awready_after_reset: got %b, required 1", axi.axi_awready);
          end
        end
        if (exp_aw) begin
          n_vec++;
          if (axi.axi_awready !== 1'b1) begin
            n_err++;
            $display("FAIL awready_after_b: got %b, required 1", axi.axi_awready);
          end
          exp_aw = 1'b0;
        end
        if (axi.axi_awvalid && axi.axi_awready) aw_cyc = ncyc;
        if (axi.axi_bvalid) begin
          n_vec++;
          if (bq.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_b: bvalid with resp %0d, required no response", axi.axi_bresp);
          end else begin
            if (axi.axi_bresp !== bq[0].resp) begin
              n_err++;
              $display("FAIL bresp: got %0d, required %0d", axi.axi_bresp, bq[0].resp);
            end
            if (!bv_prev && bq[0].lat >= 0) begin
              n_vec++;
              if (ncyc - aw_cyc != bq[0].lat) begin
                n_err++;
                $display("FAIL b_latency: got %0d cycles, required %0d", ncyc - aw_cyc, bq[0].lat);
              end
            end
            if (bv_prev) begin
              n_vec++;
              if (axi.axi_awready || axi.axi_wready) begin
                n_err++;
                $display("FAIL resp_hold: awready=%b wready=%b, required 0 0", axi.axi_awready, axi.axi_wready);
              end
            end
            if (axi.axi_bready) begin
              void'(bq.pop_front());
              exp_aw = 1'b1;
            end
          end
        end
        bv_prev = axi.axi_bvalid && !axi.axi_bready;
        while (dq.size() > 0 && dq[0].due <= ncyc) begin
          n_vec++;
          if (dbg_rdata !== dq[0].exp) begin
            n_err++;
            $display("FAIL dbg_word[%0d]: got %h, required %h", dq[0].idx, dbg_rdata, dq[0].exp);
          end
          void'(dq.pop_front());
        end
      end
      if (fin_req && !fin_done) begin
        n_vec++;
        if (bq.size() != 0 || dq.size() != 0) begin
          n_err++;
          $display("FAIL queues_drained: b=%0d dbg=%0d left, required 0 0", bq.size(), dq.size());
        end
        fin_done = 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // sel: 0 = AW handshake, 1 = W handshake, 2 = bvalid seen
  task automatic wait_cond(input int sel, input string nm);
    int k = 0;
    forever begin
      @(negedge clk);
      if (sel == 0 && axi.axi_awvalid && axi.axi_awready) break;
      if (sel == 1 && axi.axi_wvalid && axi.axi_wready) break;
      if (sel == 2 && axi.axi_bvalid) break;
      k++;
      if (k > 400) begin
        $display("FAIL timeout_%s: no event within 400 cycles, required one", nm);
        $fatal(1, "bench stopped on timeout");
      end
    end
    @(posedge clk);
    #1;
  endtask

  function automatic logic wl(input int i, input int len, input int mode);
    case (mode)
      0: return i == len;
      1: return i == 0;
      2: return 1'b0;
      default: return 1'b1;
    endcase
  endfunction

  // Predicts the burst outcome from the rules, then drives it onto the bus
  task automatic do_burst(input logic [31:0] addr, input int len, input logic [2:0] size,
                          input logic [1:0] burst, input int lmode, input bit gaps,
                          input int bp, input int rst_after);
    logic [31:0] a;
    bit bad, err, inr;
    bad = !((burst == 2'b00 || burst == 2'b01) && size <= 3'd3);
    err = bad;
    a   = addr;
    for (int i = 0; i <= len; i++) begin
      err = err | (wl(i, len, lmode) != (i == len));
      inr = (a < 32'(DEPTH*8));
      err = err | !inr;
      if ((rst_after < 0 || i <= rst_after) && !bad && inr)
        for (int b = 0; b < 8; b++)
          if (bstrb[i][b]) mref[int'(a >> 3)*8 + b] = bdata[i][8*b +: 8];
      if (burst == 2'b01) a = a + (32'd1 << size);
    end
    if (rst_after < 0) bq.push_back('{resp: err ? 2'b10 : 2'b00, lat: gaps ? -1 : len + 2});

    axi.axi_bready  = (bp == 0);
    axi.axi_awaddr  = addr;
    axi.axi_awlen   = 8'(len);
    axi.axi_awsize  = size;
    axi.axi_awburst = burst;
    axi.axi_awvalid = 1'b1;
    axi.axi_wdata   = bdata[0];
    axi.axi_wstrb   = bstrb[0];
    axi.axi_wlast   = wl(0, len, lmode);
    axi.axi_wvalid  = 1'b1;
    wait_cond(0, "aw");
    axi.axi_awvalid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      if (i > 0) begin
        axi.axi_wdata = bdata[i];
        axi.axi_wstrb = bstrb[i];
        axi.axi_wlast = wl(i, len, lmode);
        if (gaps && $urandom_range(0, 2) == 0) begin
          axi.axi_wvalid = 1'b0;
          repeat ($urandom_range(1, 3)) tick();
        end
        axi.axi_wvalid = 1'b1;
      end
      wait_cond(1, "w");
      if (i == rst_after) begin
        resetn = 1'b0;
        axi.axi_wvalid = 1'b0;
        repeat (3) tick();
        resetn = 1'b1;
        repeat (3) tick();
        return;
      end
    end
    axi.axi_wvalid = 1'b0;
    axi.axi_wlast  = 1'b0;
    wait_cond(2, "b");
    if (bp > 0) begin
      repeat (bp) tick();
      axi.axi_bready = 1'b1;
      tick();
    end
    tick();
  endtask

  task automatic chk_words(input int lo, input int hi);
    logic [63:0] e;
    for (int idx = lo; idx <= hi; idx++) begin
      dbg_addr = AIW'(idx);
      for (int b = 0; b < 8; b++) e[8*b +: 8] = mref[idx*8 + b];
      dq.push_back('{due: ncyc + 2, idx: idx, exp: e});
      tick();
    end
    repeat (3) tick();
  endtask

  task automatic fill(input int len, input logic [63:0] base, input logic [7:0] s);
    for (int i = 0; i <= len; i++) begin
      bdata[i] = base + 64'(i);
      bstrb[i] = s;
    end
  endtask

  initial begin
    axi.axi_awaddr = '0; axi.axi_awlen = '0; axi.axi_awsize = '0; axi.axi_awburst = '0;
    axi.axi_awvalid = 1'b0; axi.axi_wdata = '0; axi.axi_wstrb = '0; axi.axi_wlast = 1'b0;
    axi.axi_wvalid = 1'b0; axi.axi_bready = 1'b1; dbg_addr = '0;
    repeat (4) tick();
    resetn = 1'b1;
    repeat (3) tick();

    // Preload the whole memory so the model is fully known
    for (int i = 0; i < 256; i++) begin
      bdata[i] = {$urandom, $urandom};
      bstrb[i] = 8'hFF;
    end
    do_burst(32'h0, 255, 3'd3, 2'b01, 0, 1'b0, 0, -1);

    bdata[0] = 64'h1122334455667788; bstrb[0] = 8'hFF;
    do_burst(32'h10, 0, 3'd3, 2'b01, 0, 1'b0, 0, -1);
    chk_words(2, 2);

    fill(3, 64'hA0, 8'hFF);
    do_burst(32'h0, 3, 3'd3, 2'b01, 0, 1'b0, 0, -1);
    chk_words(0, 3);

    bdata[0] = 64'hFFFFFFFF_FFFFFFFF; bstrb[0] = 8'h0F;
    bdata[1] = 64'h0;                 bstrb[1] = 8'hF0;
    do_burst(32'h8, 1, 3'd3, 2'b00, 0, 1'b0, 0, -1);
    chk_words(1, 1);

    fill(1, 64'hE0E0_0000_0000_0000, 8'hFF);
    do_burst(32'h20, 1, 3'd3, 2'b01, 1, 1'b0, 0, -1);   // wlast on beat 0
    do_burst(32'h40, 1, 3'd3, 2'b10, 0, 1'b0, 0, -1);   // WRAP
    do_burst(32'h60, 0, 3'd4, 2'b01, 0, 1'b0, 0, -1);   // size 4
    do_burst(32'h800, 0, 3'd3, 2'b01, 0, 1'b0, 0, -1);  // first word past the end
    do_burst(32'hFFFF_FFF8, 1, 3'd3, 2'b01, 0, 1'b0, 0, -1); // wraps to 0
    fill(3, 64'hC300, 8'hFF);
    do_burst(32'h7F8, 3, 3'd3, 2'b01, 0, 1'b0, 0, -1);  // runs off the top
    do_burst(32'h80, 2, 3'd3, 2'b01, 2, 1'b0, 0, -1);   // wlast missing
    do_burst(32'h90, 2, 3'd2, 2'b01, 3, 1'b0, 0, -1);   // wlast on every beat
    chk_words(0, 20);
    chk_words(252, 255);

    fill(1, 64'hB0B0, 8'hFF);
    do_burst(32'h100, 1, 3'd3, 2'b01, 0, 1'b0, 5, -1);
    chk_words(32, 33);

    fill(3, 64'hD000, 8'hFF);
    do_burst(32'h200, 3, 3'd3, 2'b01, 0, 1'b0, 0, 1);   // reset after beat 1
    chk_words(64, 67);
    fill(3, 64'hD100, 8'h3C);
    do_burst(32'h200, 3, 3'd3, 2'b01, 0, 1'b0, 0, -1);
    chk_words(64, 67);

    for (int n = 0; n < 30; n++) begin
      int r, len, lm;
      logic [2:0] sz;
      logic [1:0] bt;
      len = $urandom_range(0, 7);
      for (int i = 0; i <= len; i++) begin
        bdata[i] = {$urandom, $urandom};
        bstrb[i] = 8'($urandom);
      end
      sz = ($urandom_range(0, 9) == 0) ? 3'd4 : 3'($urandom_range(0, 3));
      r  = $urandom_range(0, 9);
      bt = (r == 0) ? 2'b10 : (r == 1) ? 2'b11 : (r <= 4) ? 2'b00 : 2'b01;
      lm = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 3) : 0;
      do_burst(32'($urandom_range(0, 270) * 8 + $urandom_range(0, 7)), len, sz, bt, lm,
               1'($urandom_range(0, 1)),
               ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0, -1);
    end
    chk_words(0, 255);

    fin_req = 1'b1;
    for (int k = 0; k < 20 && !fin_done; k++) tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
